// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// rr_pick is reused by the read-side scheduler.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int STALL_W = 16;
  localparam int RR_MAXN = 8;
  localparam int RR_IW   = 3;

  // First valid index after last, wrapping modulo n; last if none valid.
  function automatic int rr_pick(
    input logic [RR_MAXN-1:0] valid,
    input int                 last,
    input int                 n
  );
    int pick;
    int idx;
    pick = last;
    for (int k = RR_MAXN; k >= 1; k--) begin
      idx = (last + k) % n;
      if (k <= n && valid[idx[RR_IW-1:0]]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester bundle plus FIFO write port.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;

  modport master (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, winc, wdata
  );

  modport slave (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, winc, wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin picker.
// Scans last+1, last+2, ... modulo N.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_valid,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [$clog2(N)-1:0] o_pick,
  output logic                 o_any
);
  localparam int IW = $clog2(N);

  assign o_pick = IW'(rr_pick(RR_MAXN'(i_valid), int'(i_last), N));
  assign o_any  = |i_valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port
// among NREQ requesters, honouring wfull back-pressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    wclk,
  input  logic                    wrst,
  fifo_wr_arbiter_if.master       bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [STALL_W-1:0]      stall_cnt
);
  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BEAT_END = BW'(MAX_BURST - 1);

  arb_state_t         r_state, w_nstate;
  logic [GW-1:0]      r_gnt, w_ngnt;
  logic [GW-1:0]      r_last, w_nlast;
  logic [GW-1:0]      w_pick;
  logic [BW-1:0]      r_beat, w_nbeat;
  logic [STALL_W-1:0] r_stall, w_nstall;
  logic               w_any;
  logic               w_vld;
  logic               w_xfer;
  logic               w_end;
  logic [DSIZE-1:0]   w_data [NREQ];

  rr_arbiter #(.N(NREQ)) u_rr (
    .i_valid (bus.req_valid),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_any   (w_any)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_data[i] = bus.req_data[i*DSIZE +: DSIZE];
    end
  end

  assign w_vld  = bus.req_valid[r_gnt];
  assign w_xfer = (r_state == ARB_BURST) && w_vld && !bus.wfull;
  assign w_end  = bus.req_last[r_gnt] || (r_beat == BEAT_END);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_last  <= GW'(NREQ - 1);
      r_beat  <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_nstate;
      r_gnt   <= w_ngnt;
      r_last  <= w_nlast;
      r_beat  <= w_nbeat;
      r_stall <= w_nstall;
    end
  end

  always_comb begin
    w_nstate      = r_state;
    w_ngnt        = r_gnt;
    w_nlast       = r_last;
    w_nbeat       = r_beat;
    w_nstall      = r_stall;
    bus.winc      = 1'b0;
    bus.req_ready = '0;
    bus.wdata     = '0;
    busy          = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_nstate = ARB_BURST;
          w_ngnt   = w_pick;
          w_nlast  = w_pick;
          w_nbeat  = '0;
        end
      end
      ARB_BURST: begin
        busy                 = 1'b1;
        bus.winc             = w_xfer;
        bus.req_ready[r_gnt] = w_xfer;
        bus.wdata            = w_data[r_gnt];
        // Only blocked beats count; an idle requester is not a stall.
        if (w_vld && bus.wfull && (r_stall != '1)) begin
          w_nstall = r_stall + STALL_W'(1);
        end
        if (w_xfer) begin
          w_nbeat = r_beat + BW'(1);
          if (w_end) begin
            w_nstate = ARB_IDLE;
          end
        end
      end
      default: w_nstate = ARB_IDLE;
    endcase
  end

  assign grant_id  = r_gnt;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with producer and FIFO
// models; checks handshakes, write order and stall counting.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int MAXB  = 4;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] stall_cnt;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAXB)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  logic [3:0] en, hold, lastall, lastend;
  logic       ff, rd_en;
  int         len [4];
  int         sent [4];
  int         depth;
  int         fcnt;
  logic [7:0] wlog [$];
  logic [7:0] eq [$];
  int total = 0;
  int bad   = 0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = en[i] && !hold[i] && (sent[i] < len[i]);
      bus.req_last[i]  = lastall[i] || (lastend[i] && sent[i] == len[i] - 1);
      bus.req_data[i*8 +: 8] = 8'(i * 32 + sent[i]);
    end
    bus.wfull = ff || (fcnt >= depth);
  end

  always @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < 4; i++) sent[i] <= 0;
      fcnt <= 0;
      wlog.delete();
    end else begin
      for (int i = 0; i < 4; i++)
        if (bus.req_ready[i]) sent[i] <= sent[i] + 1;
      if (bus.winc) wlog.push_back(bus.wdata);
      fcnt <= fcnt + (bus.winc ? 1 : 0) - ((rd_en && fcnt > 0) ? 1 : 0);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_log(input string nm);
    chk({nm, " count"}, 64'(wlog.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size(); i++)
      if (i < wlog.size()) chk($sformatf("%s[%0d]", nm, i), 64'(wlog[i]), 64'(eq[i]));
  endtask

  task automatic to_neg();
    @(negedge wclk);
    total++;
    if (bus.winc && bus.wfull) begin
      bad++;
      $display("FAIL overrun: actual winc=1 wfull=1 required winc=0");
    end
  endtask

  task automatic to_pos();
    @(posedge wclk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      to_neg();
      to_pos();
    end
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    en = '0; hold = '0; lastall = '0; lastend = '0;
    ff = 1'b0; rd_en = 1'b0; depth = 16;
    for (int i = 0; i < 4; i++) len[i] = 0;
    #20;
    @(posedge wclk);
    #1;
    wrst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] en;
    logic       ff;
    logic       winc;
    logic [3:0] rdy;
    logic       bsy;
    logic [1:0] gnt;
    logic [7:0] wd;
  } vec_t;

  vec_t tv [13];

  initial begin
    tv[0]  = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0};
    tv[1]  = '{4'hF, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd0};
    tv[2]  = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0};
    tv[3]  = '{4'hF, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd32};
    tv[4]  = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 8'd0};
    tv[5]  = '{4'hF, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'd64};
    tv[6]  = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'd0};
    tv[7]  = '{4'hF, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'd96};
    tv[8]  = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 8'd0};
    tv[9]  = '{4'hF, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd1};
    tv[10] = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0};
    tv[11] = '{4'hF, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd33};
    tv[12] = '{4'hF, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd33};

    // Reset state
    do_reset();
    to_neg();
    chk("rst winc", 64'(bus.winc), 64'd0);
    chk("rst ready", 64'(bus.req_ready), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst wdata", 64'(bus.wdata), 64'd0);
    chk("rst grant", 64'(grant_id), 64'd0);
    chk("rst stall", 64'(stall_cnt), 64'd0);
    to_pos();

    // Round-robin, one beat per grant, table-driven
    for (int i = 0; i < 4; i++) begin
      len[i] = 100;
      lastall[i] = 1'b1;
    end
    for (int r = 0; r < 13; r++) begin
      en = tv[r].en;
      ff = tv[r].ff;
      to_neg();
      chk($sformatf("rr row%0d {winc,rdy,busy,gnt,wd}", r),
          64'({bus.winc, bus.req_ready, busy, grant_id, bus.wdata}),
          64'({tv[r].winc, tv[r].rdy, tv[r].bsy, tv[r].gnt, tv[r].wd}));
      to_pos();
    end
    ff = 1'b0;
    chk("rr stall", 64'(stall_cnt), 64'd1);
    eq = '{8'd0, 8'd32, 8'd64, 8'd96, 8'd1, 8'd33};
    chk_log("rr log");

    // Burst cap with a competing single-beat requester
    do_reset();
    len[1] = 2; lastall[1] = 1'b1;
    len[2] = 10;
    en = 4'b0110;
    begin
      int c;
      for (c = 0; c < 60 && wlog.size() < 12; c++) cyc(1);
      chk("cap cycles", 64'(c), 64'd17);
    end
    eq = '{8'd32, 8'd64, 8'd65, 8'd66, 8'd67, 8'd33,
           8'd68, 8'd69, 8'd70, 8'd71, 8'd72, 8'd73};
    chk_log("cap log");

    // Back-pressure from a 2-deep FIFO
    do_reset();
    depth = 2;
    len[0] = 3; lastend[0] = 1'b1;
    en = 4'b0001;
    cyc(1);
    to_neg();
    chk("bp beat0", 64'({bus.winc, bus.wdata}), 64'({1'b1, 8'd0}));
    to_pos();
    to_neg();
    chk("bp beat1", 64'({bus.winc, bus.wdata}), 64'({1'b1, 8'd1}));
    to_pos();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) rd_en = 1'b1;
      to_neg();
      chk($sformatf("bp blocked%0d {winc,busy}", k),
          64'({bus.winc, busy}), 64'({1'b0, 1'b1}));
      to_pos();
    end
    rd_en = 1'b0;
    to_neg();
    chk("bp resume", 64'({bus.winc, bus.wdata}), 64'({1'b1, 8'd2}));
    to_pos();
    chk("bp stall", 64'(stall_cnt), 64'd5);
    eq = '{8'd0, 8'd1, 8'd2};
    chk_log("bp log");

    // Valid gap mid-packet keeps the grant
    do_reset();
    len[3] = 3; lastend[3] = 1'b1;
    len[0] = 5; lastall[0] = 1'b1;
    en = 4'b1000;
    cyc(1);
    en = 4'b1001;
    to_neg();
    chk("gap beat0 {rdy,wd}", 64'({bus.req_ready, bus.wdata}), 64'({4'b1000, 8'd96}));
    to_pos();
    hold = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      chk($sformatf("gap hold%0d {busy,gnt,rdy,winc}", k),
          64'({busy, grant_id, bus.req_ready, bus.winc}),
          64'({1'b1, 2'd3, 4'b0000, 1'b0}));
      to_pos();
    end
    hold = 4'b0000;
    to_neg();
    chk("gap beat1 {rdy,wd}", 64'({bus.req_ready, bus.wdata}), 64'({4'b1000, 8'd97}));
    to_pos();
    to_neg();
    chk("gap beat2 {rdy,wd}", 64'({bus.req_ready, bus.wdata}), 64'({4'b1000, 8'd98}));
    to_pos();
    cyc(1);
    to_neg();
    chk("gap next {rdy,wd}", 64'({bus.req_ready, bus.wdata}), 64'({4'b0001, 8'd0}));
    to_pos();
    chk("gap stall", 64'(stall_cnt), 64'd0);
    eq = '{8'd96, 8'd97, 8'd98, 8'd0};
    chk_log("gap log");

    // Asynchronous reset during a live write
    do_reset();
    len[2] = 10;
    en = 4'b0100;
    cyc(1);
    ff = 1'b1;
    cyc(2);
    ff = 1'b0;
    to_neg();
    chk("mid {winc,busy,gnt,stall}", 64'({bus.winc, busy, grant_id, stall_cnt}),
        64'({1'b1, 1'b1, 2'd2, 16'd2}));
    #2 wrst = 1'b1;
    #1;
    chk("async rst {winc,rdy,busy,gnt,stall,wd}",
        64'({bus.winc, bus.req_ready, busy, grant_id, stall_cnt, bus.wdata}),
        64'd0);

    // Stall counter saturation
    do_reset();
    len[0] = 100;
    en = 4'b0001;
    ff = 1'b1;
    cyc(1);
    cyc(65534);
    chk("sat pre", 64'(stall_cnt), 64'd65534);
    cyc(1);
    chk("sat hit", 64'(stall_cnt), 64'hFFFF);
    cyc(4500);
    chk("sat hold", 64'(stall_cnt), 64'hFFFF);
    chk("sat nowrite", 64'(wlog.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
